// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises the pipeline's data access and instruction fetch
// onto the single level-handshake port of the RAM/UART controller, holding
// the pipeline in stall until both are complete. Reads of the UART status
// address are answered locally.
//
// state | meaning
// IDLE  | waiting for a pipeline request; latches every request input
// SEL   | picks the next unserved request (MEM before IF); answers status reads
// ACK   | request raised, waiting for the controller to drop dev_done
// BUSY  | controller working, waiting for dev_done to rise again
// DONE  | one-cycle release: valids pulse, stall drops, back to IDLE
module mem_arbiter #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter logic [15:0] TIMEOUT        = 16'd60000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_valid,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_valid,
  output logic        stall,
  output logic        timeout,
  output logic        dev_need_to_work,
  output logic        dev_rd,
  output logic        dev_wr,
  output logic [15:0] dev_addr,
  output logic [15:0] dev_wdata,
  input  logic        dev_done,
  input  logic [15:0] dev_result,
  input  logic        uart_data_ready,
  input  logic        uart_tbre,
  input  logic        uart_tsre
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    ACK  = 3'd2,
    BUSY = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;

  // Request latches, captured in IDLE and held for the whole pipeline step
  logic        req_if_q, req_if_d;
  logic        req_rd_q, req_rd_d;
  logic        req_wr_q, req_wr_d;
  logic [15:0] lat_if_addr_q, lat_if_addr_d;
  logic [15:0] lat_mem_addr_q, lat_mem_addr_d;
  logic [15:0] lat_wdata_q, lat_wdata_d;
  logic        served_mem_q, served_mem_d;
  logic        served_if_q, served_if_d;

  // Access in flight: which side it belongs to, and the abort timer
  logic        cur_mem_q, cur_mem_d;
  logic [15:0] timer_q, timer_d;

  // Registered outputs
  logic        dev_need_q, dev_need_d;
  logic        dev_rd_q, dev_rd_d;
  logic        dev_wr_q, dev_wr_d;
  logic [15:0] dev_addr_q, dev_addr_d;
  logic [15:0] dev_wdata_q, dev_wdata_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic [15:0] if_data_q, if_data_d;
  logic        timeout_q, timeout_d;

  logic        any_req;
  logic        mem_pend;
  logic        if_pend;
  logic        mem_is_stat;
  logic [15:0] uart_status;
  logic        access_end;
  logic        access_abort;
  logic [15:0] access_result;

  assign any_req     = if_req | mem_rd | mem_wr;
  assign mem_pend    = (req_rd_q | req_wr_q) & ~served_mem_q;
  assign if_pend     = req_if_q & ~served_if_q;
  assign uart_status = {14'b0, uart_data_ready, uart_tbre & uart_tsre};

  // A simultaneous read+write counts as a write, so only a pure read can be a
  // local status read. Should the two UART addresses ever be configured equal,
  // the data register wins and the read goes to the controller.
  assign mem_is_stat = req_rd_q & ~req_wr_q & (lat_mem_addr_q == UART_STAT_ADDR)
                       & (UART_STAT_ADDR != UART_DATA_ADDR);

  // Next-state and next-output computation for the sequencing FSM
  always_comb begin
    state_d        = state_q;
    req_if_d       = req_if_q;
    req_rd_d       = req_rd_q;
    req_wr_d       = req_wr_q;
    lat_if_addr_d  = lat_if_addr_q;
    lat_mem_addr_d = lat_mem_addr_q;
    lat_wdata_d    = lat_wdata_q;
    served_mem_d   = served_mem_q;
    served_if_d    = served_if_q;
    cur_mem_d      = cur_mem_q;
    timer_d        = timer_q;
    dev_need_d     = dev_need_q;
    dev_rd_d       = dev_rd_q;
    dev_wr_d       = dev_wr_q;
    dev_addr_d     = dev_addr_q;
    dev_wdata_d    = dev_wdata_q;
    mem_rdata_d    = mem_rdata_q;
    if_data_d      = if_data_q;
    timeout_d      = 1'b0;
    access_end     = 1'b0;
    access_abort   = 1'b0;
    access_result  = dev_result;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          req_if_d       = if_req;
          req_rd_d       = mem_rd;
          req_wr_d       = mem_wr;
          lat_if_addr_d  = if_addr;
          lat_mem_addr_d = mem_addr;
          lat_wdata_d    = mem_wdata;
          served_mem_d   = 1'b0;
          served_if_d    = 1'b0;
          state_d        = SEL;
        end
      end

      SEL: begin
        if (mem_pend && mem_is_stat) begin
          mem_rdata_d  = uart_status;
          served_mem_d = 1'b1;
        end else if (mem_pend) begin
          dev_addr_d  = lat_mem_addr_q;
          dev_wdata_d = lat_wdata_q;
          dev_wr_d    = req_wr_q;
          dev_rd_d    = ~req_wr_q;
          dev_need_d  = 1'b1;
          cur_mem_d   = 1'b1;
          timer_d     = TIMEOUT - 16'd1;
          state_d     = ACK;
        end else if (if_pend) begin
          dev_addr_d  = lat_if_addr_q;
          dev_wr_d    = 1'b0;
          dev_rd_d    = 1'b1;
          dev_need_d  = 1'b1;
          cur_mem_d   = 1'b0;
          timer_d     = TIMEOUT - 16'd1;
          state_d     = ACK;
        end else begin
          state_d = DONE;
        end
      end

      // The timer counts down once per ACK/BUSY cycle; reaching zero in one of
      // those cycles means TIMEOUT cycles have been spent on this access.
      ACK: begin
        if (timer_q == 16'd0) begin
          access_abort = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
          if (!dev_done) begin
            state_d = BUSY;
          end
        end
      end

      // A completion arriving on the last allowed cycle still counts.
      BUSY: begin
        if (dev_done) begin
          access_end = 1'b1;
        end else if (timer_q == 16'd0) begin
          access_abort = 1'b1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (access_end || access_abort) begin
      dev_need_d = 1'b0;
      dev_rd_d   = 1'b0;
      dev_wr_d   = 1'b0;
      timeout_d  = access_abort;
      state_d    = SEL;
      if (access_abort) begin
        access_result = 16'hFFFF;
      end
      if (cur_mem_q) begin
        served_mem_d = 1'b1;
        if (!dev_wr_q) begin
          mem_rdata_d = access_result;
        end
      end else begin
        served_if_d = 1'b1;
        if_data_d   = access_result;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      req_if_q       <= 1'b0;
      req_rd_q       <= 1'b0;
      req_wr_q       <= 1'b0;
      lat_if_addr_q  <= '0;
      lat_mem_addr_q <= '0;
      lat_wdata_q    <= '0;
      served_mem_q   <= 1'b0;
      served_if_q    <= 1'b0;
      cur_mem_q      <= 1'b0;
      timer_q        <= '0;
      dev_need_q     <= 1'b0;
      dev_rd_q       <= 1'b0;
      dev_wr_q       <= 1'b0;
      dev_addr_q     <= '0;
      dev_wdata_q    <= '0;
      mem_rdata_q    <= '0;
      if_data_q      <= '0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      req_if_q       <= req_if_d;
      req_rd_q       <= req_rd_d;
      req_wr_q       <= req_wr_d;
      lat_if_addr_q  <= lat_if_addr_d;
      lat_mem_addr_q <= lat_mem_addr_d;
      lat_wdata_q    <= lat_wdata_d;
      served_mem_q   <= served_mem_d;
      served_if_q    <= served_if_d;
      cur_mem_q      <= cur_mem_d;
      timer_q        <= timer_d;
      dev_need_q     <= dev_need_d;
      dev_rd_q       <= dev_rd_d;
      dev_wr_q       <= dev_wr_d;
      dev_addr_q     <= dev_addr_d;
      dev_wdata_q    <= dev_wdata_d;
      mem_rdata_q    <= mem_rdata_d;
      if_data_q      <= if_data_d;
      timeout_q      <= timeout_d;
    end
  end

  assign stall = (state_q == SEL) || (state_q == ACK) || (state_q == BUSY)
                 || ((state_q == IDLE) && any_req);
  assign mem_valid        = (state_q == DONE) && (req_rd_q || req_wr_q);
  assign if_valid         = (state_q == DONE) && req_if_q;
  assign timeout          = timeout_q;
  assign dev_need_to_work = dev_need_q;
  assign dev_rd           = dev_rd_q;
  assign dev_wr           = dev_wr_q;
  assign dev_addr         = dev_addr_q;
  assign dev_wdata        = dev_wdata_q;
  assign mem_rdata        = mem_rdata_q;
  assign if_data          = if_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: a level-handshake controller model plus a
// behavioural reference of which device accesses a pipeline step must produce,
// in what order, with what results and after how many cycles.
module tb_mem_arbiter;
  localparam logic [15:0] STAT_ADDR = 16'hBF01;
  localparam logic [15:0] DATA_ADDR = 16'hBF00;
  localparam logic [15:0] TMO       = 16'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic        dev_done = 1'b1;
  logic [15:0] dev_result = '0;
  logic        uart_data_ready = 1'b0;
  logic        uart_tbre = 1'b0;
  logic        uart_tsre = 1'b0;
  logic [15:0] if_data, mem_rdata, dev_addr, dev_wdata;
  logic        if_valid, mem_valid, stall, timeout, dev_need_to_work, dev_rd, dev_wr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .UART_DATA_ADDR(DATA_ADDR),
    .UART_STAT_ADDR(STAT_ADDR),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .stall(stall), .timeout(timeout),
    .dev_need_to_work(dev_need_to_work), .dev_rd(dev_rd), .dev_wr(dev_wr),
    .dev_addr(dev_addr), .dev_wdata(dev_wdata), .dev_done(dev_done), .dev_result(dev_result),
    .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre), .uart_tsre(uart_tsre)
  );

  // Controller model: idles with dev_done=1, drops it when a request is seen,
  // raises it again (with a result) ctl_delay+1 cycles later.
  int          ctl_delay = 0;
  bit          ctl_hang = 1'b0;
  bit          ctl_fixed = 1'b0;
  logic [15:0] ctl_fixed_val = '0;
  bit          ctl_busy = 1'b0;
  int          ctl_cnt = 0;
  logic        need_prev = 1'b0;
  logic [33:0] cap_bus = '0;
  logic [15:0] log_addr[$];
  logic [15:0] log_wdata[$];
  logic        log_rd[$];
  logic        log_wr[$];
  logic [15:0] log_res[$];
  int mon_need = 0, mon_to = 0, mon_mv = 0, mon_iv = 0, mon_stab = 0;

  initial begin : controller
    forever begin
      @(negedge clk);
      if (rst) begin
        dev_done  = 1'b1;
        ctl_busy  = 1'b0;
        need_prev = 1'b0;
      end else begin
        if (dev_need_to_work && !need_prev) begin
          cap_bus = {dev_rd, dev_wr, dev_addr, dev_wdata};
          log_addr.push_back(dev_addr);
          log_wdata.push_back(dev_wdata);
          log_rd.push_back(dev_rd);
          log_wr.push_back(dev_wr);
        end
        if (dev_need_to_work) begin
          mon_need++;
          if ({dev_rd, dev_wr, dev_addr, dev_wdata} !== cap_bus) mon_stab++;
        end
        if (timeout)   mon_to++;
        if (mem_valid) mon_mv++;
        if (if_valid)  mon_iv++;
        need_prev = dev_need_to_work;
        if (ctl_hang) begin
          dev_done = 1'b0;
        end else if (ctl_busy) begin
          if (ctl_cnt == 0) begin
            dev_result = ctl_fixed ? ctl_fixed_val : 16'($urandom);
            log_res.push_back(dev_result);
            dev_done = 1'b1;
            ctl_busy = 1'b0;
          end else begin
            ctl_cnt--;
          end
        end else if (dev_need_to_work && dev_done) begin
          dev_done = 1'b0;
          ctl_busy = 1'b1;
          ctl_cnt  = ctl_delay;
        end else if (!dev_need_to_work) begin
          dev_done = 1'b1;
        end
      end
    end
  end

  // Observations of the most recent pipeline step
  int          obs_cyc, obs_need, obs_to, obs_mv, obs_iv, obs_stab;
  bit          obs_stall_ok, obs_mv_done, obs_iv_done;
  logic [15:0] obs_mrd, obs_ifd;

  // Presents one set of requests in an IDLE cycle (cycle 0) and follows it to
  // the cycle where a valid appears, then releases the inputs.
  task automatic run_access(input logic i_req, input logic [15:0] i_addr,
                            input logic m_rd, input logic m_wr,
                            input logic [15:0] m_addr, input logic [15:0] m_wdata,
                            input int delay);
    int n0, t0, mv0, iv0, s0;
    @(negedge clk);
    log_addr.delete(); log_wdata.delete(); log_rd.delete(); log_wr.delete(); log_res.delete();
    n0 = mon_need; t0 = mon_to; mv0 = mon_mv; iv0 = mon_iv; s0 = mon_stab;
    ctl_delay = delay;
    if_req = i_req; if_addr = i_addr;
    mem_rd = m_rd; mem_wr = m_wr; mem_addr = m_addr; mem_wdata = m_wdata;
    #1;
    obs_stall_ok = (stall === 1'b1);
    obs_cyc = -1; obs_mv_done = 1'b0; obs_iv_done = 1'b0; obs_mrd = 'x; obs_ifd = 'x;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (mem_valid === 1'b1 || if_valid === 1'b1) begin
        obs_cyc = c; obs_mrd = mem_rdata; obs_ifd = if_data;
        obs_mv_done = mem_valid; obs_iv_done = if_valid;
        if (stall !== 1'b0) obs_stall_ok = 1'b0;
        break;
      end
      if (stall !== 1'b1) obs_stall_ok = 1'b0;
    end
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    obs_need = mon_need - n0; obs_to = mon_to - t0;
    obs_mv = mon_mv - mv0; obs_iv = mon_iv - iv0; obs_stab = mon_stab - s0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({dev_need_to_work, dev_rd, dev_wr, dev_addr, dev_wdata} !== 35'd0) begin
      errors++; $display("FAIL reset_dev got %h expected 0", {dev_need_to_work, dev_rd, dev_wr, dev_addr, dev_wdata});
    end
    checks++;
    if ({if_data, mem_rdata} !== 32'd0) begin
      errors++; $display("FAIL reset_data got %h expected 0", {if_data, mem_rdata});
    end
    checks++;
    if ({stall, timeout, mem_valid, if_valid} !== 4'd0) begin
      errors++; $display("FAIL reset_flags got %b expected 0000", {stall, timeout, mem_valid, if_valid});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Fetch only; the controller answers 4A21 five cycles after the request.
  task automatic test_fetch;
    ctl_fixed = 1'b1; ctl_fixed_val = 16'h4A21;
    run_access(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0, 3);
    ctl_fixed = 1'b0;
    checks++;
    if (obs_cyc !== 8) begin errors++; $display("FAIL fetch_latency got %0d expected 8", obs_cyc); end
    checks++;
    if (log_addr.size() != 1) begin
      errors++; $display("FAIL fetch_windows got %0d expected 1", log_addr.size());
    end else begin
      checks++;
      if ({log_rd[0], log_wr[0], log_addr[0]} !== {1'b1, 1'b0, 16'h0004}) begin
        errors++; $display("FAIL fetch_op got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=0004", log_rd[0], log_wr[0], log_addr[0]);
      end
    end
    checks++;
    if (obs_ifd !== 16'h4A21) begin errors++; $display("FAIL fetch_data got %h expected 4a21", obs_ifd); end
    checks++;
    if ({obs_iv, obs_mv} !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL fetch_pulses got if=%0d mem=%0d expected if=1 mem=0", obs_iv, obs_mv);
    end
    checks++;
    if (!obs_stall_ok) begin errors++; $display("FAIL fetch_stall got bad stall expected high until DONE"); end
  endtask

  // Data write and fetch in the same step: write first, then fetch.
  task automatic test_write_then_fetch;
    run_access(1'b1, 16'h0005, 1'b0, 1'b1, 16'h8010, 16'h1234, 1);
    checks++;
    if (log_addr.size() != 2 || log_res.size() != 2) begin
      errors++; $display("FAIL wf_count got %0d expected 2", log_addr.size());
    end else begin
      checks++;
      if ({log_rd[0], log_wr[0], log_addr[0], log_wdata[0]} !== {1'b0, 1'b1, 16'h8010, 16'h1234}) begin
        errors++; $display("FAIL wf_first got rd=%b wr=%b addr=%h wdata=%h expected write 8010/1234", log_rd[0], log_wr[0], log_addr[0], log_wdata[0]);
      end
      checks++;
      if ({log_rd[1], log_wr[1], log_addr[1]} !== {1'b1, 1'b0, 16'h0005}) begin
        errors++; $display("FAIL wf_second got rd=%b wr=%b addr=%h expected read 0005", log_rd[1], log_wr[1], log_addr[1]);
      end
      checks++;
      if (obs_ifd !== log_res[1]) begin errors++; $display("FAIL wf_ifdata got %h expected %h", obs_ifd, log_res[1]); end
    end
    checks++;
    if ({obs_mv_done, obs_iv_done, obs_mv, obs_iv} !== {1'b1, 1'b1, 32'd1, 32'd1}) begin
      errors++; $display("FAIL wf_done got mv=%b iv=%b pulses %0d/%0d expected both in one DONE", obs_mv_done, obs_iv_done, obs_mv, obs_iv);
    end
    checks++;
    if (obs_cyc !== 2 + 2 * (3 + 1)) begin errors++; $display("FAIL wf_latency got %0d expected 10", obs_cyc); end
  endtask

  task automatic test_status;
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b0;
    run_access(1'b0, 16'h0, 1'b1, 1'b0, STAT_ADDR, 16'h0, 0);
    checks++;
    if (obs_need !== 0) begin errors++; $display("FAIL stat_nodev got %0d need cycles expected 0", obs_need); end
    checks++;
    if (obs_mrd !== 16'h0002) begin errors++; $display("FAIL stat_data got %h expected 0002", obs_mrd); end
    checks++;
    if (obs_cyc !== 3) begin errors++; $display("FAIL stat_latency got %0d expected 3", obs_cyc); end
  endtask

  task automatic test_rd_wr_both;
    run_access(1'b0, 16'h0, 1'b1, 1'b1, 16'h9000, 16'h5A5A, 0);
    checks++;
    if (log_addr.size() != 1) begin
      errors++; $display("FAIL rw_count got %0d expected 1", log_addr.size());
    end else begin
      checks++;
      if ({log_rd[0], log_wr[0], log_addr[0]} !== {1'b0, 1'b1, 16'h9000}) begin
        errors++; $display("FAIL rw_op got rd=%b wr=%b addr=%h expected rd=0 wr=1 addr=9000", log_rd[0], log_wr[0], log_addr[0]);
      end
    end
  endtask

  task automatic test_timeout;
    ctl_hang = 1'b1;
    run_access(1'b0, 16'h0, 1'b1, 1'b0, 16'h1234, 16'h0, 0);
    checks++;
    if (obs_need !== 16) begin errors++; $display("FAIL to_window got %0d cycles expected 16", obs_need); end
    checks++;
    if (obs_to !== 1) begin errors++; $display("FAIL to_pulse got %0d expected 1", obs_to); end
    checks++;
    if (obs_mrd !== 16'hFFFF) begin errors++; $display("FAIL to_data got %h expected ffff", obs_mrd); end
    checks++;
    if (obs_cyc !== 19) begin errors++; $display("FAIL to_latency got %0d expected 19", obs_cyc); end
    checks++;
    if (dev_need_to_work !== 1'b0) begin errors++; $display("FAIL to_need_after got %b expected 0", dev_need_to_work); end
    ctl_hang = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid;
    int seen;
    seen = 0;
    @(negedge clk);
    ctl_delay = 10;
    mem_rd = 1'b1; mem_addr = 16'h2000;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (dev_need_to_work === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (seen != 1) begin errors++; $display("FAIL rstmid_start got no request expected dev_need_to_work"); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; mem_rd = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({dev_need_to_work, stall, mem_valid, if_valid, timeout} !== 5'd0) begin
      errors++; $display("FAIL rstmid_outs got need/stall/mv/iv/to=%b expected 00000", {dev_need_to_work, stall, mem_valid, if_valid, timeout});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random pipeline steps against a reference of the expected access list.
  task automatic test_random;
    logic [15:0] exp_mrd, exp_ifd, exp_addr[2], exp_wd[2], m_addr, m_wd, i_addr, stat;
    logic        exp_wr[2], i_req, m_rd, m_wr, local_stat;
    int          kind, d, exp_n, exp_cyc;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    exp_mrd = '0; exp_ifd = '0;
    for (int it = 0; it < 25; it++) begin
      kind = $urandom_range(0, 5);
      d = $urandom_range(0, 4);
      i_req = (kind == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      i_addr = 16'($urandom);
      m_addr = 16'($urandom);
      if (m_addr == STAT_ADDR) m_addr = 16'h0100;
      m_wd = 16'($urandom);
      m_rd = (kind == 1) || (kind == 3) || (kind == 4) || (kind == 5);
      m_wr = (kind == 2) || (kind == 3);
      if (kind == 4) m_addr = STAT_ADDR;
      if (kind == 5) m_addr = DATA_ADDR;
      uart_data_ready = 1'($urandom_range(0, 1));
      uart_tbre = 1'($urandom_range(0, 1));
      uart_tsre = 1'($urandom_range(0, 1));
      stat = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
      local_stat = m_rd && !m_wr && (m_addr == STAT_ADDR);
      exp_n = 0;
      if ((m_rd || m_wr) && !local_stat) begin
        exp_addr[exp_n] = m_addr; exp_wr[exp_n] = m_wr; exp_wd[exp_n] = m_wd; exp_n++;
      end
      if (i_req) begin
        exp_addr[exp_n] = i_addr; exp_wr[exp_n] = 1'b0; exp_wd[exp_n] = '0; exp_n++;
      end
      exp_cyc = 2 + (local_stat ? 1 : 0) + exp_n * (3 + d);
      run_access(i_req, i_addr, m_rd, m_wr, m_addr, m_wd, d);
      checks++;
      if (obs_cyc !== exp_cyc) begin errors++; $display("FAIL rnd%0d_latency got %0d expected %0d", it, obs_cyc, exp_cyc); end
      checks++;
      if (log_addr.size() != exp_n || log_res.size() != exp_n) begin
        errors++; $display("FAIL rnd%0d_count got %0d expected %0d", it, log_addr.size(), exp_n);
      end else begin
        for (int k = 0; k < exp_n; k++) begin
          checks++;
          if ({log_rd[k], log_wr[k], log_addr[k]} !== {~exp_wr[k], exp_wr[k], exp_addr[k]}
              || (exp_wr[k] && log_wdata[k] !== exp_wd[k])) begin
            errors++; $display("FAIL rnd%0d_op%0d got rd=%b wr=%b addr=%h wd=%h expected wr=%b addr=%h wd=%h", it, k, log_rd[k], log_wr[k], log_addr[k], log_wdata[k], exp_wr[k], exp_addr[k], exp_wd[k]);
          end
        end
        if (local_stat) exp_mrd = stat;
        else if (m_rd && !m_wr) exp_mrd = log_res[0];
        if (i_req) exp_ifd = log_res[exp_n - 1];
        if (m_rd || m_wr) begin
          checks++;
          if (obs_mrd !== exp_mrd) begin errors++; $display("FAIL rnd%0d_mrdata got %h expected %h", it, obs_mrd, exp_mrd); end
        end
        if (i_req) begin
          checks++;
          if (obs_ifd !== exp_ifd) begin errors++; $display("FAIL rnd%0d_ifdata got %h expected %h", it, obs_ifd, exp_ifd); end
        end
      end
      checks++;
      if ({obs_mv, obs_iv, obs_to} !== {32'(m_rd || m_wr), 32'(i_req), 32'd0}) begin
        errors++; $display("FAIL rnd%0d_pulses got mv=%0d iv=%0d to=%0d expected mv=%0d iv=%0d to=0", it, obs_mv, obs_iv, obs_to, m_rd || m_wr, i_req);
      end
      checks++;
      if (!obs_stall_ok || obs_stab != 0) begin
        errors++; $display("FAIL rnd%0d_stall_stable got stall_ok=%b unstable=%0d expected 1/0", it, obs_stall_ok, obs_stab);
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got no finish expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    test_reset();
    test_fetch();
    test_write_then_fetch();
    test_status();
    test_rd_wr_both();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
